pipeline_fg_prefetch: RTL

PIPELINE_FG_PREFETCH -- requirements
Module: pipeline_fg_prefetch

---
 rtl/pipeline_fg_prefetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipeline_fg_prefetch.sv
// Foreground pixel prefetcher: issues credit-limited line fetches to the memory
// reader and buffers the returned pixels in a small FIFO for the chroma-key stage.
module pipeline_fg_prefetch #(
  parameter int R_WIDTH     = 5,
  parameter int G_WIDTH     = 6,
  parameter int B_WIDTH     = 5,
  parameter int PIXEL_SIZE  = R_WIDTH + G_WIDTH + B_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int LINE_PIXELS = 640,
  parameter int X_WIDTH     = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic                  pixel_advance,
  output logic                  mem_req,
  output logic [X_WIDTH-1:0]    mem_index,
  input  logic                  mem_ready,
  input  logic                  mem_valid,
  input  logic [PIXEL_SIZE-1:0] mem_pixel,
  output logic [PIXEL_SIZE-1:0] fg_pixel_out,
  output logic                  fg_pixel_ready,
  output logic                  underrun
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DISC_W = CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    LINE_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [PIXEL_SIZE-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, outstanding;
  logic [CNT_W:0]        credit_used;
  logic [DISC_W-1:0]     discard, disc_sum;
  logic [X_WIDTH-1:0]    req_index;

  logic flush, accept, drop, push, pop, ret_dec, last_req, full, empty;

  assign flush       = line_start | frame_start;
  assign accept      = mem_req & mem_ready;
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign drop        = mem_valid & (discard != '0);
  assign pop         = pixel_advance & ~empty & ~flush;
  // A push into a full FIFO is only taken when the same edge pops the head.
  assign push        = mem_valid & (discard == '0) & ~flush & (~full | pop);
  assign ret_dec     = mem_valid & ~drop & (outstanding != '0);
  assign last_req    = (req_index == X_WIDTH'(LINE_PIXELS - 1));
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign disc_sum    = discard + DISC_W'(outstanding);

  assign mem_index      = req_index;
  assign fg_pixel_ready = ~empty;
  assign fg_pixel_out   = empty ? '0 : fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (line_start) begin
      state_next = FETCH;
    end else if (frame_start) begin
      state_next = IDLE;
    end else if (state == FETCH && accept && last_req) begin
      state_next = LINE_DONE;
    end
  end

  always_comb begin
    mem_req = 1'b0;
    if (state == FETCH && !flush && credit_used < (CNT_W + 1)'(FIFO_DEPTH)) begin
      mem_req = 1'b1;
    end
  end

  // Requests still in flight at a flush are converted into pixels to discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      discard     <= '0;
      req_index   <= '0;
    end else if (flush) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      discard     <= disc_sum - DISC_W'(mem_valid && (disc_sum != '0));
      req_index   <= '0;
    end else begin
      count     <= count + CNT_W'(push) - CNT_W'(pop);
      wr_ptr    <= wr_ptr + PTR_W'(push);
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      discard   <= discard - DISC_W'(drop);
      req_index <= req_index + X_WIDTH'(accept);
      if (accept && !ret_dec) begin
        outstanding <= outstanding + 1'b1;
      end else if (!accept && ret_dec) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (frame_start) begin
      underrun <= 1'b0;
    end else if (pixel_advance && empty && state != IDLE && !line_start) begin
      underrun <= 1'b1;
    end
  end

endmodule
